// File: rtl/wave_gen_mc_if.sv
// Configuration write port of wave_gen_mc: valid/ready handshake plus per-channel settings.
interface wave_gen_mc_if #(
  parameter int CHANNELS  = 4,
  parameter int ACC_WIDTH = 16,
  parameter int CNT_WIDTH = 16
);
  localparam int CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [CHAN_W-1:0]    cfg_chan;
  logic [ACC_WIDTH-1:0] cfg_freq;
  logic [1:0]           cfg_shape;
  logic [CNT_WIDTH-1:0] cfg_duty;
  logic [7:0]           cfg_gain;

  modport master (
    output cfg_valid, cfg_chan, cfg_freq, cfg_shape, cfg_duty, cfg_gain,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_chan, cfg_freq, cfg_shape, cfg_duty, cfg_gain,
    output cfg_ready
  );
endinterface

// File: rtl/wave_gen_mc.sv
// Multi-channel phase-accumulator oscillator bank with per-channel gain and saturating mixer.
// Define WAVE_GEN_MC_SYNC_UPDATE_EN for shadowed, wrap-synchronised configuration updates.
module wave_gen_mc #(
  parameter int CHANNELS   = 4,
  parameter int ACC_WIDTH  = 16,
  parameter int WAVE_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         tick,
  input  logic [CHANNELS-1:0]          chan_en,
  wave_gen_mc_if.slave                 cfg,
  output logic signed [WAVE_WIDTH-1:0] out,
  output logic                         out_valid
);
  localparam int SCL_W = WAVE_WIDTH + 9;
  localparam int SUM_W = SCL_W + $clog2(CHANNELS);
  localparam logic signed [WAVE_WIDTH-1:0] PEAK  = {1'b0, {(WAVE_WIDTH-1){1'b1}}};
  localparam logic signed [WAVE_WIDTH-1:0] FLOOR = {1'b1, {(WAVE_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    SHAPE_SQUARE = 2'd0,
    SHAPE_SAW    = 2'd1,
    SHAPE_TRI    = 2'd2,
    SHAPE_OFF    = 2'd3
  } shape_e;

  typedef struct packed {
    logic [ACC_WIDTH-1:0] freq;
    shape_e               shape;
    logic [CNT_WIDTH-1:0] duty;
    logic [7:0]           gain;
  } chan_cfg_t;

  localparam chan_cfg_t CFG_ZERO = '{freq: '0, shape: SHAPE_SQUARE, duty: '0, gain: '0};

  logic [ACC_WIDTH-1:0]    phase_q  [CHANNELS];
  logic [ACC_WIDTH-1:0]    phase_d  [CHANNELS];
  chan_cfg_t               act_q    [CHANNELS];
  chan_cfg_t               act_d    [CHANNELS];
  logic signed [SCL_W-1:0] scaled_q [CHANNELS];
  logic signed [SCL_W-1:0] scaled_d [CHANNELS];
  logic                    stage_vld_q;
  logic signed [WAVE_WIDTH-1:0] out_q, out_d;
  logic                    out_vld_q;
  logic                    rdy_q;
  logic                    wr_acc;
  chan_cfg_t               wr_cfg;

`ifdef WAVE_GEN_MC_SYNC_UPDATE_EN
  chan_cfg_t               shd_q [CHANNELS];
  chan_cfg_t               shd_d [CHANNELS];
  logic [CHANNELS-1:0]     pend_q, pend_d;
  logic                    busy;

  always_comb begin
    busy = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (pend_q[c] && int'(cfg.cfg_chan) == c) busy = 1'b1;
    end
  end

  assign cfg.cfg_ready = rdy_q && !busy;
`else
  assign cfg.cfg_ready = rdy_q;
`endif

  assign wr_acc = cfg.cfg_valid && cfg.cfg_ready;
  assign wr_cfg = '{freq:  cfg.cfg_freq,
                    shape: shape_e'(cfg.cfg_shape),
                    duty:  cfg.cfg_duty,
                    gain:  cfg.cfg_gain};

  function automatic logic signed [WAVE_WIDTH-1:0] wave_sample(chan_cfg_t cc,
                                                               logic [ACC_WIDTH-1:0] ph);
    logic [WAVE_WIDTH-1:0] u;
    logic [CNT_WIDTH-1:0]  p;
    logic [WAVE_WIDTH-2:0] f;
    u = ph[ACC_WIDTH-1 -: WAVE_WIDTH];
    p = ph[ACC_WIDTH-1 -: CNT_WIDTH];
    f = u[WAVE_WIDTH-1] ? ~u[WAVE_WIDTH-2:0] : u[WAVE_WIDTH-2:0];
    wave_sample = '0;
    case (cc.shape)
      SHAPE_SQUARE: wave_sample = (p < cc.duty) ? PEAK : -PEAK;
      SHAPE_SAW:    wave_sample = u ^ FLOOR;
      SHAPE_TRI:    wave_sample = {f, 1'b0} - PEAK;
      default:      wave_sample = '0;
    endcase
  endfunction

  always_comb begin
    // NOTE: each next-state signal takes its hold value first, so no path can infer a latch.
    phase_d = phase_q;
    act_d   = act_q;
`ifdef WAVE_GEN_MC_SYNC_UPDATE_EN
    shd_d   = shd_q;
    pend_d  = pend_q;
`endif
    for (int c = 0; c < CHANNELS; c++) begin
      if (!chan_en[c])  phase_d[c] = '0;
      else if (tick)    phase_d[c] = phase_q[c] + act_q[c].freq;
`ifdef WAVE_GEN_MC_SYNC_UPDATE_EN
      // An accumulator carry shows up as the advanced phase landing below the old one.
      if (pend_q[c] && (!chan_en[c] || (tick && phase_d[c] < phase_q[c]))) begin
        act_d[c]  = shd_q[c];
        pend_d[c] = 1'b0;
      end
      if (wr_acc && int'(cfg.cfg_chan) == c) begin
        shd_d[c]  = wr_cfg;
        pend_d[c] = 1'b1;
      end
`else
      if (wr_acc && int'(cfg.cfg_chan) == c) act_d[c] = wr_cfg;
`endif
    end
  end

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      logic signed [WAVE_WIDTH-1:0] smp;
      logic signed [SCL_W-1:0]      prod;
      smp  = chan_en[c] ? wave_sample(act_q[c], phase_q[c]) : '0;
      prod = SCL_W'(smp) * SCL_W'($signed({1'b0, act_q[c].gain}));
      scaled_d[c] = tick ? (prod >>> 7) : scaled_q[c];
    end
  end

  always_comb begin
    logic signed [SUM_W-1:0] sum;
    sum = '0;
    for (int c = 0; c < CHANNELS; c++) sum = sum + SUM_W'(scaled_q[c]);
    out_d = out_q;
    if (stage_vld_q) begin
      if (sum > SUM_W'(PEAK))       out_d = PEAK;
      else if (sum < SUM_W'(FLOOR)) out_d = FLOOR;
      else                          out_d = sum[WAVE_WIDTH-1:0];
    end
  end

  // NOTE: registers update with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rdy_q       <= 1'b0;
      // NOTE: the per-channel arrays are reset too, since every channel must read zero after reset.
      phase_q     <= '{default: '0};
      act_q       <= '{default: CFG_ZERO};
      scaled_q    <= '{default: '0};
      stage_vld_q <= 1'b0;
      out_q       <= '0;
      out_vld_q   <= 1'b0;
`ifdef WAVE_GEN_MC_SYNC_UPDATE_EN
      shd_q       <= '{default: CFG_ZERO};
      pend_q      <= '0;
`endif
    end else begin
      rdy_q       <= 1'b1;
      phase_q     <= phase_d;
      act_q       <= act_d;
      scaled_q    <= scaled_d;
      stage_vld_q <= tick;
      out_q       <= out_d;
      out_vld_q   <= stage_vld_q;
`ifdef WAVE_GEN_MC_SYNC_UPDATE_EN
      shd_q       <= shd_d;
      pend_q      <= pend_d;
`endif
    end
  end

  assign out       = out_q;
  assign out_valid = out_vld_q;
endmodule
